// File: rtl/multi_rate_divider.sv
// Bank of independent programmable tick dividers. Each channel counts 0..P and
// emits a one-cycle tick every P+1 clocks, or a single tick in one-shot mode.
module multi_rate_divider #(
    parameter int               WIDTH          = 28,
    parameter int               CHANNELS       = 4,
    parameter int               CH_W           = 2,
    parameter logic [WIDTH-1:0] PERIOD_DEFAULT = 28'd5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic                cfg_oneshot,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] active,
    output logic                any_tick
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] period_reg;
            logic [WIDTH-1:0] cnt_reg;
            logic             oneshot_reg;
            logic             active_reg;
            logic             tick_reg;
            logic             cfg_hit;

            // Channel numbers at or above CHANNELS never match, so such writes fall away.
            assign cfg_hit = cfg_we && (cfg_ch == CH_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    period_reg  <= PERIOD_DEFAULT;
                    oneshot_reg <= 1'b0;
                    active_reg  <= 1'b0;
                    cnt_reg     <= '0;
                    tick_reg    <= 1'b0;
                end else begin
                    if (cfg_hit) begin
                        period_reg  <= cfg_period;
                        oneshot_reg <= cfg_oneshot;
                    end

                    if (stop[gi]) begin
                        active_reg <= 1'b0;
                        cnt_reg    <= '0;
                        tick_reg   <= 1'b0;
                    end else if (start[gi]) begin
                        active_reg <= 1'b1;
                        cnt_reg    <= '0;
                        tick_reg   <= 1'b0;
                    end else if (active_reg) begin
                        // >= rather than == so a period lowered under cnt fires at once.
                        if (cnt_reg >= period_reg) begin
                            tick_reg <= 1'b1;
                            cnt_reg  <= '0;
                            if (oneshot_reg) begin
                                active_reg <= 1'b0;
                            end
                        end else begin
                            tick_reg <= 1'b0;
                            cnt_reg  <= cnt_reg + WIDTH'(1);
                        end
                    end else begin
                        tick_reg <= 1'b0;
                        cnt_reg  <= '0;
                    end
                end
            end

            assign tick[gi]   = tick_reg;
            assign active[gi] = active_reg;
        end
    endgenerate

    assign any_tick = |tick;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider: a default-sized instance plus a
// 4-bit, 3-channel instance for the channel-select and all-ones period bounds.
module tb_multi_rate_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [27:0] cfg_period;
    logic        cfg_oneshot;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  tick;
    logic [3:0]  active;
    logic        any_tick;

    logic        b_cfg_we;
    logic [1:0]  b_cfg_ch;
    logic [3:0]  b_cfg_period;
    logic        b_cfg_oneshot;
    logic [2:0]  b_start;
    logic [2:0]  b_stop;
    logic [2:0]  b_tick;
    logic [2:0]  b_active;
    logic        b_any_tick;

    int errors = 0;
    int checks = 0;

    multi_rate_divider dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
        .start(start), .stop(stop), .tick(tick), .active(active),
        .any_tick(any_tick)
    );

    multi_rate_divider #(
        .WIDTH(4), .CHANNELS(3), .CH_W(2), .PERIOD_DEFAULT(4'd7)
    ) dut_small (
        .clk(clk), .reset(reset), .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch),
        .cfg_period(b_cfg_period), .cfg_oneshot(b_cfg_oneshot),
        .start(b_start), .stop(b_stop), .tick(b_tick), .active(b_active),
        .any_tick(b_any_tick)
    );

    task automatic test_reset();
        reset = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
        start = '0; stop = '0;
        b_cfg_we = 1'b0; b_cfg_ch = '0; b_cfg_period = '0; b_cfg_oneshot = 1'b0;
        b_start = '0; b_stop = '0;
        repeat (2) @(negedge clk);
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick: got %h expected 0", tick); end
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL reset_active: got %h expected 0", active); end
        checks++; if (any_tick !== 1'b0) begin errors++; $display("FAIL reset_any_tick: got %b expected 0", any_tick); end
        checks++; if (b_tick !== 3'h0 || b_active !== 3'h0) begin errors++; $display("FAIL reset_small: got tick %h active %h expected 0 0", b_tick, b_active); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL reset_release_active: got %h expected 0", active); end
        $display("test_reset: done");
    endtask

    task automatic test_periodic();
        bit exp;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 28'd3; cfg_oneshot = 1'b0;
        @(negedge clk);
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL cfg_no_start: got %b expected 0", active[0]); end
        cfg_we = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        checks++; if (active[0] !== 1'b1 || tick[0] !== 1'b0) begin errors++; $display("FAIL periodic_start: got active %b tick %b expected 1 0", active[0], tick[0]); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp = (k % 4 == 0);
            checks++; if (tick[0] !== exp || any_tick !== exp || active[0] !== 1'b1) begin
                errors++; $display("FAIL periodic k=%0d: got tick %b any %b active %b expected %b %b 1", k, tick[0], any_tick, active[0], exp, exp);
            end
        end
        stop[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        checks++; if (active[0] !== 1'b0 || tick[0] !== 1'b0) begin errors++; $display("FAIL periodic_stop: got active %b tick %b expected 0 0", active[0], tick[0]); end
        $display("test_periodic: ch0 P=3, 12 cycles observed");
    endtask

    task automatic test_oneshot();
        // Configuration and start land on the same edge.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 28'd5; cfg_oneshot = 1'b1; start[1] = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start[1] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++; if (tick[1] !== (k == 6) || active[1] !== (k < 6)) begin
                errors++; $display("FAIL oneshot k=%0d: got tick %b active %b expected %b %b", k, tick[1], active[1], (k == 6), (k < 6));
            end
        end
        $display("test_oneshot: ch1 P=5 single pulse");
    endtask

    task automatic test_p0();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 28'd0; cfg_oneshot = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0; start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (tick[2] !== 1'b1) begin errors++; $display("FAIL p0 k=%0d: got %b expected 1", k, tick[2]); end
        end
        stop[2] = 1'b1;
        @(negedge clk);
        stop[2] = 1'b0;
        checks++; if (tick[2] !== 1'b0 || active[2] !== 1'b0) begin errors++; $display("FAIL p0_stop: got tick %b active %b expected 0 0", tick[2], active[2]); end
        $display("test_p0: ch2 continuous tick");
    endtask

    task automatic test_period_change();
        bit seen;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 28'd100; cfg_oneshot = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tick[0]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL change_early: got %b expected 0", seen); end
        // cnt is 50 here; the write edge still compares against 100.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 28'd10;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++; if (tick[0] !== 1'b0 || active[0] !== 1'b1) begin errors++; $display("FAIL change_write_edge: got tick %b active %b expected 0 1", tick[0], active[0]); end
        @(negedge clk);
        checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL change_next_edge: got %b expected 1", tick[0]); end
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            checks++; if (tick[0] !== (k % 11 == 0)) begin errors++; $display("FAIL change k=%0d: got %b expected %b", k, tick[0], (k % 11 == 0)); end
        end
        stop[0] = 1'b1;
        @(negedge clk);
        stop[0] = 1'b0;
        $display("test_period_change: ch0 P 100 -> 10 at cnt=50");
    endtask

    task automatic test_stop_start();
        bit seen;
        start[3] = 1'b1; stop[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0; stop[3] = 1'b0;
        checks++; if (active[3] !== 1'b0 || tick[3] !== 1'b0) begin errors++; $display("FAIL stop_wins: got active %b tick %b expected 0 0", active[3], tick[3]); end
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 28'd9; cfg_oneshot = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0; start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (tick[3]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL restart_pre: got %b expected 0", seen); end
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        checks++; if (active[3] !== 1'b1 || tick[3] !== 1'b0) begin errors++; $display("FAIL restart_edge: got active %b tick %b expected 1 0", active[3], tick[3]); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++; if (tick[3] !== (k == 10)) begin errors++; $display("FAIL restart k=%0d: got %b expected %b", k, tick[3], (k == 10)); end
        end
        stop[3] = 1'b1;
        @(negedge clk);
        stop[3] = 1'b0;
        $display("test_stop_start: ch3 restart at cnt=7, P=9");
    endtask

    task automatic test_reset_async();
        bit seen;
        // Periods now: ch0=10, ch1=5 one-shot, ch2=0, ch3=9.
        start = 4'hF;
        @(negedge clk);
        start = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (any_tick !== 1'b1 || active !== 4'hF) begin errors++; $display("FAIL pre_reset: got any %b active %h expected 1 f", any_tick, active); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL async_tick: got %h expected 0", tick); end
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL async_active: got %h expected 0", active); end
        checks++; if (any_tick !== 1'b0) begin errors++; $display("FAIL async_any_tick: got %b expected 0", any_tick); end
        start = 4'hF; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 28'd1;
        repeat (2) @(negedge clk);
        checks++; if (active !== 4'h0) begin errors++; $display("FAIL strobe_in_reset: got %h expected 0", active); end
        reset = 1'b0; start = 4'h0; cfg_we = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (any_tick || (|active)) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got %b expected 0", seen); end
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 5001; k++) begin
            @(negedge clk);
            if (k < 5001 && tick[0]) seen = 1'b1;
            if (k == 5001) begin
                checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL default_period_tick: got %b expected 1", tick[0]); end
            end
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL default_period_early: got %b expected 0", seen); end
        stop = 4'hF;
        @(negedge clk);
        stop = 4'h0;
        $display("test_reset_async: reset mid-count, default period 5000 restored");
    endtask

    task automatic test_bounds();
        logic [2:0] exp;
        b_cfg_we = 1'b1; b_cfg_ch = 2'd3; b_cfg_period = 4'd2; b_cfg_oneshot = 1'b1;
        @(negedge clk);
        b_cfg_we = 1'b0;
        checks++; if (b_active !== 3'h0 || b_tick !== 3'h0) begin errors++; $display("FAIL bad_ch_write: got active %h tick %h expected 0 0", b_active, b_tick); end
        b_cfg_we = 1'b1; b_cfg_ch = 2'd0; b_cfg_period = 4'hF; b_cfg_oneshot = 1'b0;
        @(negedge clk);
        b_cfg_we = 1'b0; b_start = 3'b111;
        @(negedge clk);
        b_start = 3'b000;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = {(k == 8 || k == 16), (k == 8 || k == 16), (k == 16)};
            checks++; if (b_tick !== exp) begin errors++; $display("FAIL bounds k=%0d: got %b expected %b", k, b_tick, exp); end
        end
        b_stop = 3'b111;
        @(negedge clk);
        b_stop = 3'b000;
        $display("test_bounds: cfg_ch=3 ignored, P=15 ticks at 16th edge");
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_p0();
        test_period_change();
        test_stop_start();
        test_reset_async();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_rate_divider.md
MULTI_RATE_DIVIDER -- requirements
Module: multi_rate_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 28: width of the period and counter registers.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent divider channels.
REQ-003 SHALL have parameter CH_W, default 2: width of the channel select, with 2**CH_W >= CHANNELS.
REQ-004 SHALL have parameter PERIOD_DEFAULT, default 28'd5000: reset value of every channel period.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe, sampled on clk.
REQ-008 SHALL have port cfg_ch  input  CH_W  channel targeted by the configuration write.
REQ-009 SHALL have port cfg_period  input  WIDTH  period value P to load.
REQ-010 SHALL have port cfg_oneshot  input  1  mode to load: 1 = one-shot, 0 = periodic.
REQ-011 SHALL have port start  input  CHANNELS  per-channel start strobe.
REQ-012 SHALL have port stop  input  CHANNELS  per-channel stop strobe.
REQ-013 SHALL have port tick  output  CHANNELS  registered one-cycle enable pulse per channel.
REQ-014 SHALL have port active  output  CHANNELS  registered running flag per channel.
REQ-015 SHALL have port any_tick  output  1  OR of all tick bits (combinational from the tick registers).

Function
REQ-016 Each channel SHALL hold period[WIDTH], oneshot, active, cnt[WIDTH] and tick registers.
REQ-017 On cfg_we with cfg_ch < CHANNELS, period and oneshot of that channel SHALL load at the edge; cfg_ch >= CHANNELS SHALL be ignored.
REQ-018 A configuration write SHALL NOT change active or cnt.
REQ-019 Start edge (start[i]=1, stop[i]=0) SHALL set active=1 and cnt=0, including when already active (restart).
REQ-020 Stop edge (stop[i]=1) SHALL clear active, clear cnt and clear tick at that edge; stop SHALL win over simultaneous start.
REQ-021 While active and not started/stopped: if cnt >= period, tick<=1 and cnt<=0; otherwise tick<=0 and cnt<=cnt+1.
REQ-022 Tick period SHALL be P+1 clocks; the first tick SHALL be high in the cycle after the (P+1)th edge following the start edge.
REQ-023 P=0 SHALL give tick high every cycle while active in periodic mode.
REQ-024 The >= compare SHALL ensure that a period lowered below the current cnt ticks on the next edge, with no wrap through 2**WIDTH.
REQ-025 The counter SHALL never exceed the all-ones value; the increment is WIDTH bits with no carry-out.
REQ-026 One-shot mode: the edge that sets tick SHALL also clear active; tick then falls on the following edge, and exactly one pulse is produced per start.
REQ-027 While inactive: tick=0 and cnt SHALL hold 0.
REQ-028 A configuration write and a start on the same channel at the same edge SHALL count against the newly written period and mode.
REQ-029 Channels SHALL be fully independent; any combination of simultaneous strobes SHALL be legal.

Reset
REQ-030 Asserting reset SHALL immediately, without clk, force: period=PERIOD_DEFAULT, oneshot=0, active=0, cnt=0, tick=0 on all channels, giving any_tick=0.
REQ-031 Reset asserted mid-count SHALL discard progress; after release, no tick SHALL occur until a new start.
REQ-032 Strobes SHALL be ignored while reset is high.

Verification
REQ-033 Periodic: write ch0 P=3, start[0] -> tick[0] high one cycle every 4 clocks, first pulse after the 4th edge; active[0] stays 1.
REQ-034 One-shot/P=0: write ch1 P=5 oneshot=1, start[1] -> single tick on the 6th edge with active[1] cleared at that edge; write ch2 P=0 periodic, start[2] -> tick[2] continuously high.
REQ-035 Period change: ch0 P=100 running, at cnt=50 write P=10 -> tick on the next edge, then every 11 clocks.
REQ-036 Stop/start: start and stop on ch3 at the same edge -> active[3]=0; start while running at cnt=7 with P=9 -> next tick after 10 more edges.
REQ-037 Reset: assert reset asynchronously mid-count on all channels -> tick, active and any_tick go 0 before the next clk edge, and period reads back as 5000 via 5001-clock spacing after restart.
REQ-038 Bounds: cfg write with cfg_ch=3 when CHANNELS=3 -> no state change; P=all-ones -> no spurious tick before 2**WIDTH clocks (check with WIDTH=4).
